// File: rtl/bp_fe_queue_ckpt_if.sv
// fe_queue handshake bundle between the FE producer/BE consumer and the checkpointing queue.
// The master drives entries and BE controls; the slave (the queue) drives status and the head entry.
interface bp_fe_queue_ckpt_if #(
    parameter int width_p = 128
);
    logic [width_p-1:0] fe_queue_i;
    logic               fe_queue_v_i;
    logic               fe_queue_ready_o;
    logic [width_p-1:0] fe_queue_o;
    logic               fe_queue_v_o;
    logic               fe_queue_yumi_i;
    logic               fe_queue_deq_i;
    logic               fe_queue_roll_i;
    logic               fe_queue_clr_i;
    logic               empty_o;

    modport master (
        output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
               fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
        input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o
    );

    modport slave (
        input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
               fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
        output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o
    );
endinterface

// File: rtl/bp_fe_queue_ckpt.sv
// Checkpointing FE-to-BE queue: write, speculative read and commit pointers keep
// issued-but-uncommitted entries replayable until the BE commits, rolls back or clears.
module bp_fe_queue_ckpt #(
    parameter int width_p = 128,
    parameter int els_p   = 8,
    localparam int idx_width_lp = $clog2(els_p),
    localparam int ptr_width_lp = idx_width_lp + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    bp_fe_queue_ckpt_if.slave fe_q
);
    localparam logic [ptr_width_lp-1:0] full_count_lp = ptr_width_lp'(els_p);
    localparam logic [ptr_width_lp-1:0] one_lp        = ptr_width_lp'(1);

    logic [width_p-1:0]      mem [els_p];
    logic [ptr_width_lp-1:0] wptr_reg, rptr_reg, cptr_reg;
    logic [ptr_width_lp-1:0] wptr_next, rptr_next, cptr_next;
    logic [ptr_width_lp-1:0] cptr_commit;
    logic                    ready, enq, issue, commit;

    // Occupancy counts issued entries too, so a queue full of uncommitted work stalls the FE.
    assign ready  = (wptr_reg - cptr_reg) != full_count_lp;
    assign enq    = fe_q.fe_queue_v_i & ready & ~fe_q.fe_queue_clr_i;
    assign issue  = fe_q.fe_queue_yumi_i & ~fe_q.fe_queue_roll_i & ~fe_q.fe_queue_clr_i;
    assign commit = fe_q.fe_queue_deq_i & (cptr_reg != rptr_reg) & ~fe_q.fe_queue_clr_i;

    assign cptr_commit = commit ? cptr_reg + one_lp : cptr_reg;

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        cptr_next = cptr_commit;
        if (fe_q.fe_queue_clr_i) begin
            rptr_next = wptr_reg;
            cptr_next = wptr_reg;
        end else begin
            if (enq) begin
                wptr_next = wptr_reg + one_lp;
            end
            // A roll lands on the post-commit checkpoint so a same-cycle deq is not replayed.
            if (fe_q.fe_queue_roll_i) begin
                rptr_next = cptr_commit;
            end else if (issue) begin
                rptr_next = rptr_reg + one_lp;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            cptr_reg <= cptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr_reg[idx_width_lp-1:0]] <= fe_q.fe_queue_i;
        end
    end

    assign fe_q.fe_queue_ready_o = ready;
    assign fe_q.fe_queue_v_o     = rptr_reg != wptr_reg;
    assign fe_q.fe_queue_o       = mem[rptr_reg[idx_width_lp-1:0]];
    assign fe_q.empty_o          = wptr_reg == cptr_reg;
endmodule

// File: tb/tb_bp_fe_queue_ckpt.sv
// Directed bench for bp_fe_queue_ckpt: fixed stimulus steps with hand-computed expectations.
module tb_bp_fe_queue_ckpt;
    localparam int W = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    bp_fe_queue_ckpt_if #(.width_p(W)) q_if ();

    bp_fe_queue_ckpt #(.width_p(W), .els_p(8)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .fe_q    (q_if.slave)
    );

    function automatic logic [W-1:0] ent(input int n);
        return {32'hF0E0_0000 | 32'(n), 32'hC0DE_0000 + 32'(n), 32'h1234_5678 ^ 32'(n), 32'(n)};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q_if.fe_queue_i      = '0;
        q_if.fe_queue_v_i    = 1'b0;
        q_if.fe_queue_yumi_i = 1'b0;
        q_if.fe_queue_deq_i  = 1'b0;
        q_if.fe_queue_roll_i = 1'b0;
        q_if.fe_queue_clr_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input int n);
        q_if.fe_queue_v_i = 1'b1;
        q_if.fe_queue_i   = ent(n);
        step();
        q_if.fe_queue_v_i = 1'b0;
    endtask

    task automatic issue_expect(input string tag, input int n);
        check(tag, q_if.fe_queue_o, ent(n));
        q_if.fe_queue_yumi_i = 1'b1;
        step();
        q_if.fe_queue_yumi_i = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        check("rst_ready", W'(q_if.fe_queue_ready_o), W'(1));
        check("rst_v", W'(q_if.fe_queue_v_o), W'(0));
        check("rst_empty", W'(q_if.empty_o), W'(1));

        // enqueue A,B,C then issue and commit them
        push(1);
        check("t1_v_after_A", W'(q_if.fe_queue_v_o), W'(1));
        check("t1_head_A", q_if.fe_queue_o, ent(1));
        push(2);
        push(3);
        issue_expect("t1_iss_A", 1);
        issue_expect("t1_iss_B", 2);
        issue_expect("t1_iss_C", 3);
        check("t1_v_drained", W'(q_if.fe_queue_v_o), W'(0));
        check("t1_not_empty", W'(q_if.empty_o), W'(0));
        q_if.fe_queue_deq_i = 1'b1;
        step(); step(); step();
        q_if.fe_queue_deq_i = 1'b0;
        check("t1_empty", W'(q_if.empty_o), W'(1));

        // fill, issue all, full stall, commit one, wrapped enqueue
        do_reset();
        for (int i = 0; i < 8; i++) push(10 + i);
        check("t2_full_ready", W'(q_if.fe_queue_ready_o), W'(0));
        q_if.fe_queue_yumi_i = 1'b1;
        for (int i = 0; i < 8; i++) step();
        q_if.fe_queue_yumi_i = 1'b0;
        check("t2_iss_v", W'(q_if.fe_queue_v_o), W'(0));
        check("t2_iss_ready", W'(q_if.fe_queue_ready_o), W'(0));
        push(50);
        check("t2_blocked_wptr", W'(dut.wptr_reg), W'(8));
        q_if.fe_queue_deq_i = 1'b1;
        step();
        q_if.fe_queue_deq_i = 1'b0;
        check("t2_ready_after", W'(q_if.fe_queue_ready_o), W'(1));
        push(99);
        check("t2_wptr9", W'(dut.wptr_reg), W'(9));
        check("t2_wrap_head", q_if.fe_queue_o, ent(99));
        check("t2_full_again", W'(q_if.fe_queue_ready_o), W'(0));

        // roll replays uncommitted entries oldest first
        do_reset();
        for (int i = 1; i <= 4; i++) push(i);
        issue_expect("t3_iss_A", 1);
        issue_expect("t3_iss_B", 2);
        issue_expect("t3_iss_C", 3);
        q_if.fe_queue_deq_i = 1'b1;
        step();
        q_if.fe_queue_deq_i  = 1'b0;
        q_if.fe_queue_roll_i = 1'b1;
        q_if.fe_queue_yumi_i = 1'b1;
        step();
        idle();
        check("t3_roll_v", W'(q_if.fe_queue_v_o), W'(1));
        issue_expect("t3_replay_B", 2);
        issue_expect("t3_replay_C", 3);
        issue_expect("t3_replay_D", 4);
        check("t3_drained", W'(q_if.fe_queue_v_o), W'(0));

        // roll with a same-cycle commit
        do_reset();
        for (int i = 1; i <= 3; i++) push(i);
        issue_expect("t4_iss_A", 1);
        issue_expect("t4_iss_B", 2);
        q_if.fe_queue_roll_i = 1'b1;
        q_if.fe_queue_deq_i  = 1'b1;
        step();
        idle();
        check("t4_rptr", W'(dut.rptr_reg), W'(1));
        check("t4_cptr", W'(dut.cptr_reg), W'(1));
        check("t4_head_B", q_if.fe_queue_o, ent(2));

        // clear discards everything including a concurrent enqueue
        do_reset();
        for (int i = 1; i <= 5; i++) push(i);
        issue_expect("t5_iss_1", 1);
        q_if.fe_queue_clr_i  = 1'b1;
        q_if.fe_queue_v_i    = 1'b1;
        q_if.fe_queue_i      = ent(77);
        q_if.fe_queue_yumi_i = 1'b1;
        q_if.fe_queue_deq_i  = 1'b1;
        step();
        idle();
        check("t5_empty", W'(q_if.empty_o), W'(1));
        check("t5_v", W'(q_if.fe_queue_v_o), W'(0));
        check("t5_ready", W'(q_if.fe_queue_ready_o), W'(1));
        check("t5_wptr", W'(dut.wptr_reg), W'(5));
        push(88);
        check("t5_next_head", q_if.fe_queue_o, ent(88));

        // ignored deq, then asynchronous reset between edges
        do_reset();
        for (int i = 1; i <= 4; i++) push(i);
        q_if.fe_queue_deq_i = 1'b1;
        step();
        q_if.fe_queue_deq_i = 1'b0;
        check("t6_wptr", W'(dut.wptr_reg), W'(4));
        check("t6_rptr", W'(dut.rptr_reg), W'(0));
        check("t6_cptr", W'(dut.cptr_reg), W'(0));
        check("t6_pre_empty", W'(q_if.empty_o), W'(0));
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_v", W'(q_if.fe_queue_v_o), W'(0));
        check("t6_async_empty", W'(q_if.empty_o), W'(1));
        check("t6_async_ready", W'(q_if.fe_queue_ready_o), W'(1));
        step();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bp_fe_queue_ckpt.md
# bp_fe_queue_ckpt

Checkpointing FE-to-BE instruction queue on the FE side of the fe_queue interface: the FE pushes PC/instruction entries, the BE scheduler issues them speculatively, then commits (deq), rewinds (roll) or flushes (clr). Three pointers (write, speculative read, commit) keep issued-but-uncommitted entries replayable until the BE commits them. It instantiates between the FE pc-gen/icache output and the BE checker's fe_queue ports.

## Interface
- width_p, 128, entry width in bits (fe_queue_width_lp at instantiation)
- els_p, 8, queue depth; power of two, >= 2
- ptr_width_lp, $clog2(els_p)+1, pointer width including wrap bit (derived)

- clk_i  input  1  clock; all state updates on rising edge
- reset_i  input  1  asynchronous, active-high reset
- fe_queue_i  input  width_p  entry from FE
- fe_queue_v_i  input  1  entry valid
- fe_queue_ready_o  output  1  space available; enqueue occurs when v_i & ready_o
- fe_queue_o  output  width_p  entry at speculative read pointer
- fe_queue_v_o  output  1  an unissued entry is present
- fe_queue_yumi_i  input  1  BE issued fe_queue_o this cycle; legal only when v_o
- fe_queue_deq_i  input  1  BE commits oldest issued entry
- fe_queue_roll_i  input  1  rewind read pointer to commit pointer
- fe_queue_clr_i  input  1  discard all entries
- empty_o  output  1  no entries held at all (committed == written); used for FE fence

## Operation
- State: mem[els_p] of width_p; wptr, rptr, cptr, each ptr_width_lp bits; index = low $clog2(els_p) bits; wrap bit distinguishes full from empty.
- Invariant: cptr <= rptr <= wptr (modular), wptr - cptr <= els_p.
- fe_queue_ready_o = (wptr - cptr) != els_p; depends only on registered state (no same-cycle deq bypass).
- fe_queue_v_o = (rptr != wptr); fe_queue_o = mem[rptr index] (combinational read, first-word fall-through).
- empty_o = (wptr == cptr).
- Enqueue (v_i & ready_o & ~clr_i): mem[wptr] <= fe_queue_i; wptr <= wptr+1.
- Issue (yumi_i & ~roll_i & ~clr_i): rptr <= rptr+1.
- Commit (deq_i & cptr != rptr & ~clr_i): cptr <= cptr+1. deq_i with cptr == rptr is ignored.
- Roll (roll_i & ~clr_i): rptr <= next cptr (cptr+1 if a commit occurs in the same cycle, else cptr); yumi_i that cycle is ignored; enqueue still proceeds.
- Clear (clr_i): wptr, rptr, cptr all <= wptr (queue empties); enqueue, yumi, deq, roll that cycle are all discarded, including a handshaken enqueue (FE is being redirected concurrently).
- Priority: clr > roll > yumi for rptr; clr > deq for cptr; clr > enqueue for wptr.
- Pointer arithmetic is modulo 2^ptr_width_lp; wrap is natural overflow.

## Timing
- Reset (async assert, sync-style release on next edge): wptr=rptr=cptr=0; fe_queue_ready_o=1, fe_queue_v_o=0, empty_o=1; mem contents undefined, fe_queue_o don't-care while v_o=0. Reset mid-operation drops all entries immediately.
- Enqueue-to-v_o latency: 1 cycle. Issue/roll/commit take effect next cycle.
- Full: ready_o=0 when els_p entries are between cptr and wptr, even if all are issued; ready_o rises the cycle after a commit.
- A roll makes previously issued entries re-appear on fe_queue_o the next cycle, oldest uncommitted first.
- Single-entry queue: enqueue and yumi of a different entry in the same cycle both legal; enqueue to an empty queue is not bypassed to fe_queue_o in the same cycle.

## Test plan
- Reset then enqueue A,B,C on cycles 1-3 -> v_o=1 from cycle 2, fe_queue_o=A; yumi on A,B,C -> v_o=0 after C, empty_o=0; three deq -> empty_o=1.
- Fill els_p=8 entries, issue all, no deq -> ready_o=0, v_o=0; one deq -> ready_o=1 next cycle; ninth enqueue accepted into wrapped slot 0 with wptr=9.
- Enqueue A..D, issue A,B,C, deq A, then roll -> next cycle fe_queue_o=B, v_o=1; issuing yields B,C,D in order.
- Roll and deq in same cycle with cptr at A, rptr at C -> rptr=cptr=B next cycle, fe_queue_o=B.
- clr with 5 entries held and simultaneous enqueue/yumi/deq -> next cycle empty_o=1, v_o=0, ready_o=1, enqueued entry absent.
- Assert reset_i asynchronously between clock edges with 4 entries held -> outputs go to reset values without waiting for a clock edge; deq_i while cptr==rptr leaves all pointers unchanged.
